// File: rtl/zx_bus_snoop.sv
`default_nettype none
// ============================================================================
// zx_bus_snoop : captures Z80 screen-RAM writes into a FWFT FIFO, tracks border
// Revision     : 1.0
// ============================================================================
module zx_bus_snoop #(
    parameter logic [15:0] BASE_ADDR    = 16'h4000,
    parameter int          SCREEN_BYTES = 6912,
    parameter int          FIFO_DEPTH   = 4
) (
    input  logic        CLK,
    input  logic        RESET,
    input  logic [15:0] A,
    input  logic [7:0]  D,
    input  logic        MREQ,
    input  logic        IORQ,
    input  logic        WR,
    input  logic        M1,
    output logic        WR_VALID,
    input  logic        WR_READY,
    output logic [12:0] WADDR,
    output logic [7:0]  WDATA,
    output logic [2:0]  BORDER,
    output logic        OVERFLOW,
    output logic [15:0] WRITE_COUNT
);

    localparam int c_PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int c_CNT_W = c_PTR_W + 1;
    localparam logic [c_CNT_W-1:0] c_FULL = c_CNT_W'(FIFO_DEPTH);
    localparam logic [16:0] c_LAST = 17'(BASE_ADDR) + 17'(SCREEN_BYTES) - 17'd1;

    localparam logic [1:0] c_ST_IDLE   = 2'd0;
    localparam logic [1:0] c_ST_QUAL   = 2'd1;
    localparam logic [1:0] c_ST_ACTIVE = 2'd2;

    logic        r_wr_s1, r_wr_s2;
    logic        r_mreq_s1, r_mreq_s2;
    logic        r_iorq_s1, r_iorq_s2;
    logic        r_m1_s1, r_m1_s2;
    logic [15:0] r_a_s1, r_a_s2;
    logic [7:0]  r_d_s1, r_d_s2;
    logic [1:0]  r_prime;

    logic [1:0]  r_state;
    logic [1:0]  w_state_nxt;
    logic        w_cap_mem;
    logic        w_cap_io;

    logic [12:0]        r_mem_addr [FIFO_DEPTH];
    logic [7:0]         r_mem_data [FIFO_DEPTH];
    logic [c_PTR_W-1:0] r_wr_ptr;
    logic [c_PTR_W-1:0] r_rd_ptr;
    logic [c_CNT_W-1:0] r_count;
    logic [2:0]         r_border;
    logic               r_overflow;
    logic [15:0]        r_write_count;

    logic        w_in_range;
    logic [12:0] w_off;
    logic        w_push_req;
    logic        w_push;
    logic        w_pop;
    logic        w_full;
    logic        w_valid;

    // Strobes reset to their inactive (high) level; bus stages track the strobes
    // stage for stage so address/data are aligned with the synced WR.
    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            r_wr_s1   <= 1'b1;
            r_wr_s2   <= 1'b1;
            r_mreq_s1 <= 1'b1;
            r_mreq_s2 <= 1'b1;
            r_iorq_s1 <= 1'b1;
            r_iorq_s2 <= 1'b1;
            r_m1_s1   <= 1'b1;
            r_m1_s2   <= 1'b1;
            r_a_s1    <= 16'd0;
            r_a_s2    <= 16'd0;
            r_d_s1    <= 8'd0;
            r_d_s2    <= 8'd0;
            r_prime   <= 2'b00;
        end else begin
            r_wr_s1   <= WR;
            r_wr_s2   <= r_wr_s1;
            r_mreq_s1 <= MREQ;
            r_mreq_s2 <= r_mreq_s1;
            r_iorq_s1 <= IORQ;
            r_iorq_s2 <= r_iorq_s1;
            r_m1_s1   <= M1;
            r_m1_s2   <= r_m1_s1;
            r_a_s1    <= A;
            r_a_s2    <= r_a_s1;
            r_d_s1    <= D;
            r_d_s2    <= r_d_s1;
            r_prime   <= {r_prime[0], 1'b1};
        end
    end

    // The FSM is frozen until the synchronizer holds real samples; otherwise the
    // reset value of synced WR (high) would let ACTIVE fall to IDLE and capture
    // a write that was already in progress at reset release.
    always_comb begin
        w_state_nxt = r_state;
        w_cap_mem   = 1'b0;
        w_cap_io    = 1'b0;
        if (r_prime[1]) begin
            case (r_state)
                c_ST_IDLE: begin
                    if (!r_wr_s2)
                        w_state_nxt = c_ST_QUAL;
                end
                c_ST_QUAL: begin
                    if (r_wr_s2) begin
                        w_state_nxt = c_ST_IDLE;
                    end else begin
                        w_state_nxt = c_ST_ACTIVE;
                        if (!r_mreq_s2)
                            w_cap_mem = 1'b1;
                        else if (!r_iorq_s2 && r_m1_s2)
                            w_cap_io = 1'b1;
                    end
                end
                c_ST_ACTIVE: begin
                    if (r_wr_s2)
                        w_state_nxt = c_ST_IDLE;
                end
                default: w_state_nxt = c_ST_ACTIVE;
            endcase
        end
    end

    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET)
            r_state <= c_ST_ACTIVE;
        else
            r_state <= w_state_nxt;
    end

    assign w_in_range = ({1'b0, r_a_s2} >= {1'b0, BASE_ADDR}) && ({1'b0, r_a_s2} <= c_LAST);
    // Only the low 13 bits of the offset are stored; the modular difference of
    // the low bits equals the low bits of the full difference.
    assign w_off      = r_a_s2[12:0] - BASE_ADDR[12:0];
    assign w_push_req = w_cap_mem && w_in_range;
    assign w_valid    = (r_count != '0);
    assign w_full     = (r_count == c_FULL);
    assign w_pop      = w_valid && WR_READY;
    assign w_push     = w_push_req && (!w_full || w_pop);

    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            for (int i = 0; i < FIFO_DEPTH; i++) begin
                r_mem_addr[i] <= 13'd0;
                r_mem_data[i] <= 8'd0;
            end
            r_wr_ptr      <= '0;
            r_rd_ptr      <= '0;
            r_count       <= '0;
            r_overflow    <= 1'b0;
            r_write_count <= 16'd0;
        end else begin
            if (w_push) begin
                r_mem_addr[r_wr_ptr] <= w_off;
                r_mem_data[r_wr_ptr] <= r_d_s2;
                r_wr_ptr             <= r_wr_ptr + c_PTR_W'(1);
                r_write_count        <= r_write_count + 16'd1;
            end
            if (w_pop)
                r_rd_ptr <= r_rd_ptr + c_PTR_W'(1);
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + c_CNT_W'(1);
                2'b01:   r_count <= r_count - c_CNT_W'(1);
                default: r_count <= r_count;
            endcase
            if (w_push_req && !w_push)
                r_overflow <= 1'b1;
        end
    end

    // The ULA decodes any even I/O port as its own.
    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET)
            r_border <= 3'd0;
        else if (w_cap_io && !r_a_s2[0])
            r_border <= r_d_s2[2:0];
    end

    assign WR_VALID    = w_valid;
    assign WADDR       = r_mem_addr[r_rd_ptr];
    assign WDATA       = r_mem_data[r_rd_ptr];
    assign BORDER      = r_border;
    assign OVERFLOW    = r_overflow;
    assign WRITE_COUNT = r_write_count;

endmodule
`default_nettype wire

// File: tb/tb_zx_bus_snoop.sv
`default_nettype none
// ============================================================================
// tb_zx_bus_snoop : directed self-checking bench for zx_bus_snoop
// Revision        : 1.0
// ============================================================================
module tb_zx_bus_snoop;

    logic        CLK = 1'b0;
    logic        RESET;
    logic [15:0] A;
    logic [7:0]  D;
    logic        MREQ, IORQ, WR, M1;
    logic        WR_VALID;
    logic        WR_READY;
    logic [12:0] WADDR;
    logic [7:0]  WDATA;
    logic [2:0]  BORDER;
    logic        OVERFLOW;
    logic [15:0] WRITE_COUNT;

    int n_checks = 0;
    int n_fail   = 0;

    logic [20:0] popq[$];

    zx_bus_snoop #(
        .BASE_ADDR    (16'h4000),
        .SCREEN_BYTES (6912),
        .FIFO_DEPTH   (4)
    ) dut (
        .CLK         (CLK),
        .RESET       (RESET),
        .A           (A),
        .D           (D),
        .MREQ        (MREQ),
        .IORQ        (IORQ),
        .WR          (WR),
        .M1          (M1),
        .WR_VALID    (WR_VALID),
        .WR_READY    (WR_READY),
        .WADDR       (WADDR),
        .WDATA       (WDATA),
        .BORDER      (BORDER),
        .OVERFLOW    (OVERFLOW),
        .WRITE_COUNT (WRITE_COUNT)
    );

    always #5 CLK = ~CLK;

    // Records every head entry that will be popped at the next rising edge.
    always @(negedge CLK) begin
        if (!RESET && WR_VALID && WR_READY)
            popq.push_back({WADDR, WDATA});
    end

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge CLK);
            #2;
        end
    endtask

    // mode 0: memory write, 1: I/O write, 2: I/O with M1 low (interrupt acknowledge)
    task automatic do_write(input int mode, input logic [15:0] addr, input logic [7:0] data,
                            input int low_cycles);
        A = addr;
        D = data;
        if (mode == 0) begin
            MREQ = 1'b0;
        end else begin
            IORQ = 1'b0;
            M1   = (mode == 1) ? 1'b1 : 1'b0;
        end
        WR = 1'b0;
        tick(low_cycles);
        WR   = 1'b1;
        MREQ = 1'b1;
        IORQ = 1'b1;
        M1   = 1'b1;
        tick(5);
    endtask

    task automatic test_reset;
        RESET = 1'b1;
        tick(2);
        n_checks++; if (WR_VALID !== 1'b0) begin n_fail++; $display("FAIL reset_valid: got %b want 0", WR_VALID); end
        n_checks++; if (WADDR !== 13'd0) begin n_fail++; $display("FAIL reset_waddr: got %h want 0", WADDR); end
        n_checks++; if (WDATA !== 8'd0) begin n_fail++; $display("FAIL reset_wdata: got %h want 0", WDATA); end
        n_checks++; if (BORDER !== 3'd0) begin n_fail++; $display("FAIL reset_border: got %0d want 0", BORDER); end
        n_checks++; if (OVERFLOW !== 1'b0) begin n_fail++; $display("FAIL reset_overflow: got %b want 0", OVERFLOW); end
        n_checks++; if (WRITE_COUNT !== 16'd0) begin n_fail++; $display("FAIL reset_count: got %0d want 0", WRITE_COUNT); end
    endtask

    task automatic test_wr_held_over_reset;
        A = 16'h4000; D = 8'h55; MREQ = 1'b0; WR = 1'b0; WR_READY = 1'b1;
        tick(1);
        RESET = 1'b0;
        popq.delete();
        tick(8);
        n_checks++; if (WRITE_COUNT !== 16'd0) begin n_fail++; $display("FAIL held_count: got %0d want 0", WRITE_COUNT); end
        WR = 1'b1; MREQ = 1'b1;
        tick(5);
        n_checks++; if (popq.size() != 0) begin n_fail++; $display("FAIL held_pops: got %0d want 0", popq.size()); end
    endtask

    task automatic test_mem_write;
        WR_READY = 1'b1;
        popq.delete();
        A = 16'h4000; D = 8'hAA; MREQ = 1'b0; WR = 1'b0;
        tick(3);
        n_checks++; if (WR_VALID !== 1'b0) begin n_fail++; $display("FAIL latency_early: got %b want 0", WR_VALID); end
        tick(1);
        n_checks++; if (WR_VALID !== 1'b1) begin n_fail++; $display("FAIL latency_valid: got %b want 1", WR_VALID); end
        n_checks++; if (WADDR !== 13'h0) begin n_fail++; $display("FAIL mem_waddr: got %h want 0", WADDR); end
        n_checks++; if (WDATA !== 8'hAA) begin n_fail++; $display("FAIL mem_wdata: got %h want aa", WDATA); end
        n_checks++; if (WRITE_COUNT !== 16'd1) begin n_fail++; $display("FAIL mem_count: got %0d want 1", WRITE_COUNT); end
        WR = 1'b1; MREQ = 1'b1;
        tick(1);
        n_checks++; if (WR_VALID !== 1'b0) begin n_fail++; $display("FAIL mem_pulse: got %b want 0", WR_VALID); end
        tick(5);
        n_checks++; if (popq.size() != 1) begin n_fail++; $display("FAIL mem_pops: got %0d want 1", popq.size()); end
        else begin
            n_checks++; if (popq[0] !== {13'h0, 8'hAA}) begin n_fail++; $display("FAIL mem_entry: got %h want %h", popq[0], {13'h0, 8'hAA}); end
        end
    endtask

    task automatic test_addr_range;
        popq.delete();
        do_write(0, 16'h3FFF, 8'h11, 4);
        do_write(0, 16'h5AFF, 8'h22, 4);
        do_write(0, 16'h5B00, 8'h33, 4);
        n_checks++; if (popq.size() != 1) begin n_fail++; $display("FAIL range_pops: got %0d want 1", popq.size()); end
        else begin
            n_checks++; if (popq[0] !== {13'h1AFF, 8'h22}) begin n_fail++; $display("FAIL range_entry: got %h want %h", popq[0], {13'h1AFF, 8'h22}); end
        end
        n_checks++; if (WRITE_COUNT !== 16'd2) begin n_fail++; $display("FAIL range_count: got %0d want 2", WRITE_COUNT); end
    endtask

    task automatic test_border;
        popq.delete();
        do_write(1, 16'h00FE, 8'h05, 4);
        n_checks++; if (BORDER !== 3'd5) begin n_fail++; $display("FAIL border_set: got %0d want 5", BORDER); end
        do_write(1, 16'h00FF, 8'h02, 4);
        n_checks++; if (BORDER !== 3'd5) begin n_fail++; $display("FAIL border_oddport: got %0d want 5", BORDER); end
        do_write(2, 16'h00FE, 8'h03, 4);
        n_checks++; if (BORDER !== 3'd5) begin n_fail++; $display("FAIL border_intack: got %0d want 5", BORDER); end
        n_checks++; if (popq.size() != 0) begin n_fail++; $display("FAIL border_pops: got %0d want 0", popq.size()); end
        n_checks++; if (WRITE_COUNT !== 16'd2) begin n_fail++; $display("FAIL border_count: got %0d want 2", WRITE_COUNT); end
    endtask

    task automatic test_glitch;
        popq.delete();
        A = 16'h4000; D = 8'h77; MREQ = 1'b0; WR = 1'b0;
        tick(1);
        WR = 1'b1; MREQ = 1'b1;
        tick(8);
        n_checks++; if (popq.size() != 0) begin n_fail++; $display("FAIL glitch_pops: got %0d want 0", popq.size()); end
        n_checks++; if (WRITE_COUNT !== 16'd2) begin n_fail++; $display("FAIL glitch_count: got %0d want 2", WRITE_COUNT); end
    endtask

    task automatic test_full_push_pop;
        logic [20:0] exp;
        WR_READY = 1'b0;
        for (int i = 0; i < 4; i++)
            do_write(0, 16'h4100 + 16'(i), 8'h60 + 8'(i), 4);
        n_checks++; if (WRITE_COUNT !== 16'd6) begin n_fail++; $display("FAIL full_count: got %0d want 6", WRITE_COUNT); end
        popq.delete();
        A = 16'h4104; D = 8'h64; MREQ = 1'b0; WR = 1'b0;
        tick(3);
        WR_READY = 1'b1;
        tick(1);
        WR_READY = 1'b0;
        n_checks++; if (popq.size() != 1) begin n_fail++; $display("FAIL pp_pops: got %0d want 1", popq.size()); end
        n_checks++; if (WRITE_COUNT !== 16'd7) begin n_fail++; $display("FAIL pp_count: got %0d want 7", WRITE_COUNT); end
        n_checks++; if (OVERFLOW !== 1'b0) begin n_fail++; $display("FAIL pp_overflow: got %b want 0", OVERFLOW); end
        n_checks++; if (WADDR !== 13'h101) begin n_fail++; $display("FAIL pp_head: got %h want 101", WADDR); end
        WR = 1'b1; MREQ = 1'b1;
        tick(5);
        WR_READY = 1'b1;
        tick(8);
        WR_READY = 1'b0;
        n_checks++; if (popq.size() != 5) begin n_fail++; $display("FAIL pp_drain: got %0d want 5", popq.size()); end
        else begin
            for (int i = 0; i < 5; i++) begin
                exp = {13'h100 + 13'(i), 8'h60 + 8'(i)};
                n_checks++; if (popq[i] !== exp) begin n_fail++; $display("FAIL pp_entry%0d: got %h want %h", i, popq[i], exp); end
            end
        end
    endtask

    task automatic test_overflow;
        logic [20:0] exp;
        WR_READY = 1'b0;
        for (int i = 0; i < 5; i++)
            do_write(0, 16'h4000 + 16'(i), 8'h10 + 8'(i), 4);
        n_checks++; if (OVERFLOW !== 1'b1) begin n_fail++; $display("FAIL ovf_flag: got %b want 1", OVERFLOW); end
        n_checks++; if (WRITE_COUNT !== 16'd11) begin n_fail++; $display("FAIL ovf_count: got %0d want 11", WRITE_COUNT); end
        n_checks++; if (WADDR !== 13'h0 || WDATA !== 8'h10) begin n_fail++; $display("FAIL ovf_head: got %h/%h want 0/10", WADDR, WDATA); end
        popq.delete();
        WR_READY = 1'b1;
        tick(8);
        WR_READY = 1'b0;
        n_checks++; if (popq.size() != 4) begin n_fail++; $display("FAIL ovf_drain: got %0d want 4", popq.size()); end
        else begin
            for (int i = 0; i < 4; i++) begin
                exp = {13'(i), 8'h10 + 8'(i)};
                n_checks++; if (popq[i] !== exp) begin n_fail++; $display("FAIL ovf_entry%0d: got %h want %h", i, popq[i], exp); end
            end
        end
        n_checks++; if (OVERFLOW !== 1'b1) begin n_fail++; $display("FAIL ovf_sticky: got %b want 1", OVERFLOW); end
        n_checks++; if (WR_VALID !== 1'b0) begin n_fail++; $display("FAIL ovf_empty: got %b want 0", WR_VALID); end
    endtask

    task automatic test_reset_midflight;
        WR_READY = 1'b0;
        do_write(0, 16'h4010, 8'hC0, 4);
        do_write(0, 16'h4011, 8'hC1, 4);
        n_checks++; if (WR_VALID !== 1'b1) begin n_fail++; $display("FAIL mid_prefill: got %b want 1", WR_VALID); end
        #3 RESET = 1'b1;
        #1;
        n_checks++; if (WR_VALID !== 1'b0) begin n_fail++; $display("FAIL mid_valid: got %b want 0", WR_VALID); end
        n_checks++; if (WADDR !== 13'd0 || WDATA !== 8'd0) begin n_fail++; $display("FAIL mid_head: got %h/%h want 0/0", WADDR, WDATA); end
        n_checks++; if (OVERFLOW !== 1'b0) begin n_fail++; $display("FAIL mid_overflow: got %b want 0", OVERFLOW); end
        n_checks++; if (WRITE_COUNT !== 16'd0) begin n_fail++; $display("FAIL mid_count: got %0d want 0", WRITE_COUNT); end
        n_checks++; if (BORDER !== 3'd0) begin n_fail++; $display("FAIL mid_border: got %0d want 0", BORDER); end
        tick(2);
        RESET = 1'b0;
        popq.delete();
        WR_READY = 1'b1;
        tick(8);
        n_checks++; if (popq.size() != 0) begin n_fail++; $display("FAIL mid_pops: got %0d want 0", popq.size()); end
    endtask

    initial begin
        RESET = 1'b1; A = 16'h0; D = 8'h0;
        MREQ = 1'b1; IORQ = 1'b1; WR = 1'b1; M1 = 1'b1; WR_READY = 1'b0;
        test_reset();
        test_wr_held_over_reset();
        test_mem_write();
        test_addr_range();
        test_border();
        test_glitch();
        test_full_push_pop();
        test_overflow();
        test_reset_midflight();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/zx_bus_snoop.md
ZX_BUS_SNOOP -- requirements
Module: zx_bus_snoop

Interface
REQ-001 Parameter: BASE_ADDR, 16'h4000, Z80 address of the first screen byte.
REQ-002 Parameter: SCREEN_BYTES, 6912, number of bytes in the pixel plus attribute window.
REQ-003 Parameter: FIFO_DEPTH, 4, capture FIFO entries (power of two, 2..16).
REQ-004 Port: CLK  in  1  system/pixel clock; the single clock domain.
REQ-005 Port: RESET  in  1  reset; asynchronous, active-high.
REQ-006 Port: A  in  16  Z80 address bus (asynchronous to CLK).
REQ-007 Port: D  in  8  Z80 data bus (asynchronous).
REQ-008 Port: MREQ, IORQ, WR, M1  in  1 each  Z80 strobes, active-low, asynchronous.
REQ-009 Port: WR_VALID  out  1  FIFO head holds a screen write.
REQ-010 Port: WR_READY  in  1  consumer (video memory) accepts the head this cycle.
REQ-011 Port: WADDR  out  13  screen offset (A - BASE_ADDR) of the head entry.
REQ-012 Port: WDATA  out  8  data of the head entry.
REQ-013 Port: BORDER  out  3  last border colour written to ULA port.
REQ-014 Port: OVERFLOW  out  1  sticky flag; a screen write was dropped because the FIFO was full.
REQ-015 Port: WRITE_COUNT  out  16  count of accepted FIFO pushes.

Function
REQ-016 WR, MREQ, IORQ and M1 shall each pass through a 2-flop synchronizer; A and D shall pass through 2 matching register stages, so that bus and strobes stay aligned.
REQ-017 The FSM shall have three states: IDLE, QUAL and ACTIVE.
REQ-018 IDLE: synced WR low -> QUAL; otherwise stay in IDLE.
REQ-019 QUAL: synced WR high -> IDLE, treated as a glitch with no capture.
REQ-020 QUAL: synced WR low with MREQ low -> memory capture, then ACTIVE.
REQ-021 QUAL: synced WR low with IORQ low and M1 high -> I/O capture, then ACTIVE.
REQ-022 QUAL: synced WR low with any other strobe combination -> ACTIVE with no capture.
REQ-023 ACTIVE: stay until synced WR high, then -> IDLE; exactly one capture per WR low pulse.
REQ-024 Memory capture shall push {synced A - BASE_ADDR, synced D} only if BASE_ADDR <= A <= BASE_ADDR+SCREEN_BYTES-1; other addresses are dropped silently, and the comparison is unsigned over 16 bits.
REQ-025 I/O capture shall set BORDER <= synced D[2:0] when synced A[0]==0; other ports are ignored.
REQ-026 The FIFO shall be first-word-fall-through: WR_VALID = not empty, and WADDR/WDATA present the head entry.
REQ-027 A pop shall occur on any CLK edge where WR_VALID and WR_READY are both high.
REQ-028 Latency: for an empty FIFO, WR_VALID shall rise after the 3rd CLK edge following the edge that first samples WR low.
REQ-029 Push when full without a simultaneous pop: drop the entry, set OVERFLOW, and leave WRITE_COUNT unchanged.
REQ-030 Push when full with a simultaneous pop: accept both; the count stays at FIFO_DEPTH.
REQ-031 Push and pop on an empty FIFO: the push is accepted and the pop is ignored, since WR_VALID was low.
REQ-032 FIFO pointers shall wrap modulo FIFO_DEPTH.
REQ-033 WRITE_COUNT shall increment on each accepted push and wrap from 16'hFFFF to 0.
REQ-034 OVERFLOW shall clear only on RESET.
REQ-035 WADDR and WDATA may hold any value while WR_VALID is low; they shall be stable while WR_VALID is high and WR_READY is low.

Reset
REQ-036 While RESET is high: FIFO empty, WR_VALID=0, WADDR=0, WDATA=0, BORDER=0, OVERFLOW=0, WRITE_COUNT=0.
REQ-037 While RESET is high, synchronizer flops for active-low strobes shall be set to 1, and bus stages to 0.
REQ-038 The FSM shall reset to ACTIVE, so a Z80 write already in progress at reset release is ignored until WR is seen high.
REQ-039 RESET asserted mid-transfer shall discard all queued entries, with no partial pop.

Verification
REQ-040 Scenario: MREQ=0, A=16'h4000, D=8'hAA, WR low for 4 CLK, WR_READY=1 -> one WR_VALID pulse with WADDR=0, WDATA=8'hAA, and WRITE_COUNT=1.
REQ-041 Scenario: writes to A=16'h3FFF, 16'h5AFF and 16'h5B00 -> exactly one entry, WADDR=13'h1AFF; 16'h3FFF and 16'h5B00 are dropped.
REQ-042 Scenario: WR_READY=0 and 5 screen writes -> 4 entries held in order, OVERFLOW=1, WRITE_COUNT=4; then WR_READY=1 -> 4 pops in order.
REQ-043 Scenario: IORQ=0, M1=1, A=16'h00FE, D=8'h05 write -> BORDER=3'd5 and no FIFO entry; the same write with A=16'h00FF leaves BORDER unchanged.
REQ-044 Scenario: 1-CLK WR low glitch, and a WR held low across RESET release -> no push in either case.
REQ-045 Scenario: full FIFO with a simultaneous push and pop -> entry accepted, OVERFLOW stays 0, WRITE_COUNT increments.
